// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared types and codes for the calculator sequencer:
//                FSM state enum, ALU op codes, result-holder sel codes and
//                the decimal digit accumulation helper.
//  Revision    : 1.0  initial release
// ============================================================================
package calc_pkg;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    EXEC    = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_t;

  // Commands to the downstream result holder
  localparam logic [2:0] SEL_HOLD  = 3'b000;
  localparam logic [2:0] SEL_LOAD  = 3'b011;
  localparam logic [2:0] SEL_CLEAR = 3'b100;

  // Full-precision value*10 + digit. Max 255*10+9 = 2559 fits in 12 bits,
  // so any set bit above bit 7 means the entry overflowed 8 bits.
  function automatic logic [11:0] acc_digit(input logic [7:0] value,
                                            input logic [3:0] dig);
    acc_digit = ({4'd0, value} * 12'd10) + {8'd0, dig};
  endfunction

endpackage : calc_pkg
`default_nettype wire

// File: rtl/calc_alu.sv
`default_nettype none
// ============================================================================
//  Module      : calc_alu
//  Description : Combinational 8-bit ALU. add/sub are modulo 256; ovf flags
//                add carry-out or sub borrow (a < b). and/or never flag.
//  Ports       : a, b (8) operands; op (2) operation; y (8) result;
//                ovf (1) arithmetic overflow.
//  Revision    : 1.0  initial release
// ============================================================================
module calc_alu
  import calc_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  op_t        op,
  output logic [7:0] y,
  output logic       ovf
);

  logic [8:0] sum;
  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    y   = 8'd0;
    ovf = 1'b0;
    case (op)
      OP_ADD: begin
        y   = sum[7:0];
        ovf = sum[8];
      end
      OP_SUB: begin
        y   = a - b;
        ovf = (a < b);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      default: begin
        y   = 8'd0;
        ovf = 1'b0;
      end
    endcase
  end

endmodule : calc_alu
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : calc_sequencer
//  Description : Digit-entry calculator sequencer. Accumulates decimal
//                operands A and B, executes one ALU op on eq, and commands a
//                downstream result holder through sel. Supports chaining
//                from DONE (new op or repeated eq reuse the last result).
//  Ports       : clock, reset (async, active-high)
//                digit_valid/digit (4), op_valid/op (2), eq, clr : strobes
//                a_reg, b_reg, result (8) : operand and result registers
//                sel (3) : holder command, busy : in EXEC,
//                overflow : sticky arithmetic/entry overflow
//  Revision    : 1.0  initial release
// ============================================================================
module calc_sequencer
  import calc_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       op_valid,
  input  logic [1:0] op,
  input  logic       eq,
  input  logic       clr,
  output logic [7:0] a_reg,
  output logic [7:0] b_reg,
  output logic [7:0] result,
  output logic [2:0] sel,
  output logic       busy,
  output logic       overflow
);

  state_t     state_q;
  op_t        op_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] result_q;
  logic [2:0] sel_q;
  logic       busy_q;
  logic       overflow_q;

  // Digits 10-15 behave as if no strobe was present
  logic        digit_ok;
  logic [11:0] acc_a;
  logic [11:0] acc_b;
  assign digit_ok = digit_valid && (digit <= 4'd9);
  assign acc_a    = acc_digit(a_q, digit);
  assign acc_b    = acc_digit(b_q, digit);

  // From DONE, eq loads a_reg with the previous result on the same edge that
  // enters EXEC, so the ALU must already see that result as its A operand.
  logic [7:0] alu_a;
  logic [7:0] alu_y;
  logic       alu_ovf;
  assign alu_a = (state_q == DONE) ? result_q : a_q;

  calc_alu u_alu (
    .a   (alu_a),
    .b   (b_q),
    .op  (op_q),
    .y   (alu_y),
    .ovf (alu_ovf)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ENTER_A;
      op_q       <= OP_ADD;
      a_q        <= 8'd0;
      b_q        <= 8'd0;
      result_q   <= 8'd0;
      sel_q      <= SEL_HOLD;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      // sel and busy are single-cycle pulses unless set below
      sel_q  <= SEL_HOLD;
      busy_q <= 1'b0;
      if (clr) begin
        state_q    <= ENTER_A;
        op_q       <= OP_ADD;
        a_q        <= 8'd0;
        b_q        <= 8'd0;
        result_q   <= 8'd0;
        overflow_q <= 1'b0;
        sel_q      <= SEL_CLEAR;
      end else begin
        case (state_q)
          ENTER_A: begin
            // eq outranks op/digit but has no effect here, so it masks them
            if (!eq) begin
              if (op_valid) begin
                op_q    <= op_t'(op);
                b_q     <= 8'd0;
                state_q <= ENTER_B;
              end else if (digit_ok) begin
                a_q <= acc_a[7:0];
                if (|acc_a[11:8]) overflow_q <= 1'b1;
              end
            end
          end
          ENTER_B: begin
            if (eq) begin
              result_q <= alu_y;
              if (alu_ovf) overflow_q <= 1'b1;
              sel_q   <= SEL_LOAD;
              busy_q  <= 1'b1;
              state_q <= EXEC;
            end else if (op_valid) begin
              op_q <= op_t'(op);
            end else if (digit_ok) begin
              b_q <= acc_b[7:0];
              if (|acc_b[11:8]) overflow_q <= 1'b1;
            end
          end
          EXEC: begin
            state_q <= DONE;
          end
          DONE: begin
            if (eq) begin
              a_q      <= result_q;
              result_q <= alu_y;
              if (alu_ovf) overflow_q <= 1'b1;
              sel_q   <= SEL_LOAD;
              busy_q  <= 1'b1;
              state_q <= EXEC;
            end else if (op_valid) begin
              a_q     <= result_q;
              op_q    <= op_t'(op);
              b_q     <= 8'd0;
              state_q <= ENTER_B;
            end else if (digit_ok) begin
              a_q        <= {4'd0, digit};
              overflow_q <= 1'b0;
              state_q    <= ENTER_A;
            end
          end
          default: state_q <= ENTER_A;
        endcase
      end
    end
  end

  assign a_reg    = a_q;
  assign b_reg    = b_q;
  assign result   = result_q;
  assign sel      = sel_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule : calc_sequencer
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc_sequencer
//  Description : Directed self-checking bench for calc_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_calc_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       op_valid = 1'b0;
  logic [1:0] op = 2'd0;
  logic       eq = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic [7:0] result;
  logic [2:0] sel;
  logic       busy;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, AND_ = 2'b10, OR_ = 2'b11;

  calc_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .digit_valid (digit_valid),
    .digit       (digit),
    .op_valid    (op_valid),
    .op          (op),
    .eq          (eq),
    .clr         (clr),
    .a_reg       (a_reg),
    .b_reg       (b_reg),
    .result      (result),
    .sel         (sel),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of strobes, sample 1 time unit after the edge
  task automatic drive(input logic dv, input logic [3:0] d, input logic ov,
                       input logic [1:0] o, input logic e, input logic c);
    digit_valid = dv; digit = d; op_valid = ov; op = o; eq = e; clr = c;
    @(posedge clock);
    #1;
    digit_valid = 1'b0; op_valid = 1'b0; eq = 1'b0; clr = 1'b0;
  endtask

  task automatic dig(input logic [3:0] d);  drive(1'b1, d, 1'b0, 2'd0, 1'b0, 1'b0); endtask
  task automatic opv(input logic [1:0] o);  drive(1'b0, 4'd0, 1'b1, o, 1'b0, 1'b0); endtask
  task automatic do_eq();                   drive(1'b0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0); endtask
  task automatic do_clr();                  drive(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b1); endtask
  task automatic idle();                    drive(1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 1'b0); endtask

  initial begin
    // Reset state
    #12;
    check_eq("rst_a", a_reg, 0);
    check_eq("rst_b", b_reg, 0);
    check_eq("rst_res", result, 0);
    check_eq("rst_sel", sel, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ovf", overflow, 0);
    @(negedge clock);
    reset = 1'b0;

    // 12 + 34
    dig(4'd1); dig(4'd2);
    check_eq("t1_a", a_reg, 12);
    opv(ADD); dig(4'd3); dig(4'd4);
    check_eq("t1_b", b_reg, 34);
    do_eq();
    check_eq("t1_res", result, 46);
    check_eq("t1_sel", sel, 3);
    check_eq("t1_busy", busy, 1);
    check_eq("t1_ovf", overflow, 0);
    idle();
    check_eq("t1_sel_end", sel, 0);
    check_eq("t1_busy_end", busy, 0);

    // 200 + 100 -> 44 with carry, then clear
    do_clr();
    dig(4'd2); dig(4'd0); dig(4'd0);
    opv(ADD); dig(4'd1); dig(4'd0); dig(4'd0);
    do_eq();
    check_eq("t2_res", result, 44);
    check_eq("t2_ovf", overflow, 1);
    idle();
    do_clr();
    check_eq("t2_clr_sel", sel, 4);
    check_eq("t2_clr_a", a_reg, 0);
    check_eq("t2_clr_b", b_reg, 0);
    check_eq("t2_clr_res", result, 0);
    check_eq("t2_clr_ovf", overflow, 0);
    idle();
    check_eq("t2_sel_end", sel, 0);

    // 5 - 9 -> 252 with borrow, fresh digit in DONE
    dig(4'd5); opv(SUB); dig(4'd9); do_eq();
    check_eq("t3_res", result, 252);
    check_eq("t3_ovf", overflow, 1);
    idle();
    check_eq("t3_ovf_sticky", overflow, 1);
    dig(4'd7);
    check_eq("t3_a", a_reg, 7);
    check_eq("t3_ovf_clr", overflow, 0);
    dig(4'd3);
    check_eq("t3_enter_a", a_reg, 73);

    // Chaining: 10+5=15, op add, 1, eq -> 16, eq -> 17
    do_clr();
    dig(4'd1); dig(4'd0); opv(ADD); dig(4'd5); do_eq();
    check_eq("t4_res15", result, 15);
    idle();
    opv(ADD);
    check_eq("t4_chain_a", a_reg, 15);
    check_eq("t4_chain_b", b_reg, 0);
    dig(4'd1); do_eq();
    check_eq("t4_res16", result, 16);
    idle();
    do_eq();
    check_eq("t4_res17", result, 17);
    check_eq("t4_a16", a_reg, 16);
    check_eq("t4_sel", sel, 3);

    // Priority: eq beats op/digit in ENTER_B; clr beats eq
    idle();
    do_clr();
    dig(4'd3); opv(ADD); dig(4'd4);
    drive(1'b1, 4'd9, 1'b1, SUB, 1'b1, 1'b0);
    check_eq("t5_res", result, 7);
    check_eq("t5_b", b_reg, 4);
    check_eq("t5_sel", sel, 3);
    idle();
    drive(1'b0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b1);
    check_eq("t5_clr_sel", sel, 4);
    check_eq("t5_clr_res", result, 0);
    check_eq("t5_clr_busy", busy, 0);

    // eq in ENTER_A masks simultaneous op_valid
    dig(4'd1);
    drive(1'b0, 4'd0, 1'b1, OR_, 1'b1, 1'b0);
    dig(4'd2);
    check_eq("t6_a_eq_ignored", a_reg, 12);

    // AND / OR
    opv(AND_); dig(4'd1); dig(4'd0); do_eq();
    check_eq("t6_and", result, 8);
    check_eq("t6_and_ovf", overflow, 0);
    idle();
    do_clr();
    dig(4'd1); dig(4'd2); opv(OR_); dig(4'd1); dig(4'd0); do_eq();
    check_eq("t6_or", result, 14);
    idle();

    // Entry overflow: 256 wraps to 0 and flags
    do_clr();
    dig(4'd2); dig(4'd5); dig(4'd6);
    check_eq("t7_a_wrap", a_reg, 0);
    check_eq("t7_ovf", overflow, 1);

    // Async reset during EXEC
    do_clr();
    dig(4'd1); opv(ADD); dig(4'd2); do_eq();
    check_eq("t8_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("t8_rst_res", result, 0);
    check_eq("t8_rst_a", a_reg, 0);
    check_eq("t8_rst_b", b_reg, 0);
    check_eq("t8_rst_sel", sel, 0);
    check_eq("t8_rst_busy", busy, 0);
    @(negedge clock);
    reset = 1'b0;
    idle();
    check_eq("t8_no_pulse_sel", sel, 0);
    check_eq("t8_no_pulse_busy", busy, 0);
    dig(4'd12);
    check_eq("t8_dig12", a_reg, 0);
    dig(4'd4);
    check_eq("t8_dig4", a_reg, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_calc_sequencer
`default_nettype wire
